// File: rtl/seq_shift_reg_param.sv
// -----------------------------------------------------------------------------
// seq_shift_reg_param
//
// Parameterised bidirectional shift register with parallel load, a fill
// counter and a full flag. All outputs come straight from flops.
//
// Optional feature: define SEQ_SHIFT_REG_ROTATE_EN to add the 'rot' input.
// With rot=1, a shift feeds the stage that would be discarded back into the
// vacated end instead of taking 'd'.
//
// Parameters
//   WIDTH  bits per stage (>= 1)
//   DEPTH  number of stages (>= 2)
//
// Ports
//   clk    in   1             rising-edge clock
//   rst_n  in   1             asynchronous active-low reset
//   en     in   1             enable; 0 freezes all state whatever the mode
//   rot    in   1             rotate select (only with SEQ_SHIFT_REG_ROTATE_EN)
//   mode   in   2             00 hold, 01 shift-up, 10 shift-down, 11 load
//   d      in   WIDTH         serial data in
//   pd     in   DEPTH*WIDTH   parallel load data, stage i = pd[i*WIDTH +: WIDTH]
//   q      out  WIDTH         stage DEPTH-1
//   q_lo   out  WIDTH         stage 0
//   q_all  out  DEPTH*WIDTH   all stages, packed like pd
//   fill   out  clog2(DEPTH+1) number of valid stages, saturates at DEPTH
//   full   out  1             fill == DEPTH
// -----------------------------------------------------------------------------
module seq_shift_reg_param #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
`ifdef SEQ_SHIFT_REG_ROTATE_EN
  input  logic                       rot,
`endif
  input  logic [1:0]                 mode,
  input  logic [WIDTH-1:0]           d,
  input  logic [DEPTH*WIDTH-1:0]     pd,
  output logic [WIDTH-1:0]           q,
  output logic [WIDTH-1:0]           q_lo,
  output logic [DEPTH*WIDTH-1:0]     q_all,
  output logic [$clog2(DEPTH+1)-1:0] fill,
  output logic                       full
);

  localparam int FILL_W = $clog2(DEPTH + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // Stages are kept packed in the same layout as pd/q_all so q_all is a
  // plain copy of the register.
  logic [DEPTH*WIDTH-1:0] stage_reg;
  logic [DEPTH*WIDTH-1:0] stage_next;
  logic [FILL_W-1:0]      fill_reg;
  logic [FILL_W-1:0]      fill_next;
  logic                   full_reg;
  logic                   full_next;

  // Values entering the open end of the register on a shift.
  logic [WIDTH-1:0] up_in;
  logic [WIDTH-1:0] dn_in;

`ifdef SEQ_SHIFT_REG_ROTATE_EN
  assign up_in = rot ? stage_reg[(DEPTH-1)*WIDTH +: WIDTH] : d;
  assign dn_in = rot ? stage_reg[0 +: WIDTH] : d;
`else
  assign up_in = d;
  assign dn_in = d;
`endif

  // Per-stage next-value selection.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [WIDTH-1:0] cur;
      logic [WIDTH-1:0] up_src;
      logic [WIDTH-1:0] dn_src;

      assign cur = stage_reg[gi*WIDTH +: WIDTH];

      if (gi == 0) begin : g_up_end
        assign up_src = up_in;
      end else begin : g_up_mid
        assign up_src = stage_reg[(gi-1)*WIDTH +: WIDTH];
      end

      if (gi == DEPTH-1) begin : g_dn_end
        assign dn_src = dn_in;
      end else begin : g_dn_mid
        assign dn_src = stage_reg[(gi+1)*WIDTH +: WIDTH];
      end

      assign stage_next[gi*WIDTH +: WIDTH] =
        !en                ? cur                    :
        (mode == MODE_UP)   ? up_src                 :
        (mode == MODE_DOWN) ? dn_src                 :
        (mode == MODE_LOAD) ? pd[gi*WIDTH +: WIDTH] :
                              cur;
    end
  endgenerate

  // Fill counts shifts in either direction and never decrements; a load
  // marks every stage valid at once.
  always_comb begin
    fill_next = fill_reg;
    if (en) begin
      case (mode)
        MODE_UP, MODE_DOWN: begin
          if (fill_reg != FILL_MAX) begin
            fill_next = fill_reg + FILL_W'(1);
          end
        end
        MODE_LOAD: fill_next = FILL_MAX;
        MODE_HOLD: fill_next = fill_reg;
        default:   fill_next = fill_reg;
      endcase
    end
  end

  // full is registered from fill_next so it rises on the same edge fill
  // reaches DEPTH while still being a pure flop output.
  assign full_next = (fill_next == FILL_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_reg <= '0;
      fill_reg  <= '0;
      full_reg  <= 1'b0;
    end else begin
      stage_reg <= stage_next;
      fill_reg  <= fill_next;
      full_reg  <= full_next;
    end
  end

  assign q     = stage_reg[(DEPTH-1)*WIDTH +: WIDTH];
  assign q_lo  = stage_reg[0 +: WIDTH];
  assign q_all = stage_reg;
  assign fill  = fill_reg;
  assign full  = full_reg;

endmodule

// File: tb/tb_seq_shift_reg_param.sv
// -----------------------------------------------------------------------------
// tb_seq_shift_reg_param
//
// Directed testbench for seq_shift_reg_param (WIDTH=8, DEPTH=4). Expected
// values are hand-computed constants. Define SEQ_SHIFT_REG_ROTATE_EN for both
// files to include the rotate vectors.
// -----------------------------------------------------------------------------
module tb_seq_shift_reg_param;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        rot;
  logic [1:0]  mode;
  logic [7:0]  d;
  logic [31:0] pd;
  logic [7:0]  q;
  logic [7:0]  q_lo;
  logic [31:0] q_all;
  logic [2:0]  fill;
  logic        full;

  int checks_cnt;
  int errors_cnt;

  seq_shift_reg_param #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
`ifdef SEQ_SHIFT_REG_ROTATE_EN
    .rot   (rot),
`endif
    .mode  (mode),
    .d     (d),
    .pd    (pd),
    .q     (q),
    .q_lo  (q_lo),
    .q_all (q_all),
    .fill  (fill),
    .full  (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [31:0] exp_all,
                             input logic [2:0] exp_fill, input logic exp_full);
    check({tag, ".q_all"}, q_all, exp_all);
    check({tag, ".fill"},  fill,  exp_fill);
    check({tag, ".full"},  full,  exp_full);
  endtask

  // Synchronous-looking reset pulse placed between clock edges.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
  endtask

  initial begin
    checks_cnt = 0;
    errors_cnt = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    rot   = 1'b0;
    mode  = 2'b00;
    d     = 8'h00;
    pd    = 32'h0;

    // In reset: clock ignored even with an enabled load pending.
    #2;
    check_state("reset_async", 32'h0, 3'd0, 1'b0);
    en = 1'b1; mode = 2'b11; pd = 32'hFFFF_FFFF;
    tick();
    tick();
    check_state("reset_ignores_clk", 32'h0, 3'd0, 1'b0);

    // Release with en=0: first edge must not change state.
    en = 1'b0;
    rst_n = 1'b1;
    tick();
    check_state("release_en0", 32'h0, 3'd0, 1'b0);

    // Reset then hold for 3 cycles.
    en = 1'b1; mode = 2'b00;
    tick(); tick(); tick();
    check_state("hold3", 32'h0, 3'd0, 1'b0);

    // Shift-up latency.
    mode = 2'b01;
    d = 8'hA1; tick();
    check("up1.fill", fill, 3'd1);
    check("up1.q_lo", q_lo, 8'hA1);
    d = 8'hB2; tick();
    d = 8'hC3; tick();
    check("up3.fill", fill, 3'd3);
    check("up3.full", full, 1'b0);
    check("up3.q", q, 8'h00);
    d = 8'hD4; tick();
    check("up4.q", q, 8'hA1);
    check("up4.q_lo", q_lo, 8'hD4);
    check_state("up4", 32'hA1B2_C3D4, 3'd4, 1'b1);
    d = 8'hE5; tick();
    check_state("up5_sat", 32'hB2C3_D4E5, 3'd4, 1'b1);

    // Load then shift-down.
    mode = 2'b11; pd = 32'h4433_2211; tick();
    check_state("load", 32'h4433_2211, 3'd4, 1'b1);
    mode = 2'b10; d = 8'h55; tick();
    check("down.q_all", q_all, 32'h5544_3322);
    check("down.q_lo", q_lo, 8'h22);
    check("down.q", q, 8'h55);

    // Enable gating with load and shift.
    en = 1'b0; mode = 2'b11; pd = 32'hDEAD_BEEF; tick(); tick();
    check_state("en0_load", 32'h5544_3322, 3'd4, 1'b1);
    mode = 2'b01; d = 8'h99; tick();
    check_state("en0_shift", 32'h5544_3322, 3'd4, 1'b1);

    // Mixed directions: fill keeps counting up.
    do_reset();
    check_state("rst_mix", 32'h0, 3'd0, 1'b0);
    en = 1'b1;
    mode = 2'b01; d = 8'h01; tick();
    mode = 2'b01; d = 8'h02; tick();
    check_state("mix_up2", 32'h0000_0102, 3'd2, 1'b0);
    mode = 2'b10; d = 8'h03; tick();
    check_state("mix_dn1", 32'h0300_0001, 3'd3, 1'b0);
    mode = 2'b10; d = 8'h04; tick();
    check_state("mix_dn2", 32'h0403_0000, 3'd4, 1'b1);
    mode = 2'b00; tick();
    check_state("mix_hold", 32'h0403_0000, 3'd4, 1'b1);

    // Asynchronous reset after two shifts, checked before the next edge.
    do_reset();
    mode = 2'b01;
    d = 8'h11; tick();
    d = 8'h22; tick();
    check_state("pre_async", 32'h0000_1122, 3'd2, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_state("async_mid", 32'h0, 3'd0, 1'b0);
    // Reset held across an edge with a load pending: reset wins.
    mode = 2'b11; pd = 32'h1234_5678;
    tick();
    check_state("rst_wins", 32'h0, 3'd0, 1'b0);
    rst_n = 1'b1;
    tick();
    check_state("post_rst_load", 32'h1234_5678, 3'd4, 1'b1);

`ifdef SEQ_SHIFT_REG_ROTATE_EN
    // Rotate-up four times returns to the loaded pattern.
    mode = 2'b11; pd = 32'h0403_0201; tick();
    rot = 1'b1; mode = 2'b01;
    tick();
    check("rot1.q_all", q_all, 32'h0302_0104);
    tick(); tick(); tick();
    check("rot4.q_all", q_all, 32'h0403_0201);
    check("rot4.fill", fill, 3'd4);
    mode = 2'b10; tick();
    check("rotdn.q_all", q_all, 32'h0104_0302);
    rot = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_shift_reg_param.md
SEQ_SHIFT_REG_PARAM -- requirements
Module: seq_shift_reg_param

Interface
REQ-001 Parameter WIDTH, default 8: bits per stage; SHALL be >= 1.
REQ-002 Parameter DEPTH, default 4: number of stages; SHALL be >= 2.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  enable; when 0, all state SHALL hold regardless of mode.
REQ-006 mode  input  2  operation: 00 hold, 01 shift-up, 10 shift-down, 11 parallel load.
REQ-007 d  input  WIDTH  serial data in.
REQ-008 pd  input  DEPTH*WIDTH  parallel load data; stage i = pd[i*WIDTH +: WIDTH].
REQ-009 q  output  WIDTH  stage DEPTH-1 contents (registered).
REQ-010 q_lo  output  WIDTH  stage 0 contents (registered).
REQ-011 q_all  output  DEPTH*WIDTH  all stages, packed as pd (registered).
REQ-012 fill  output  clog2(DEPTH+1)  number of valid stages, 0..DEPTH.
REQ-013 full  output  1  high when fill == DEPTH.

Function
REQ-014 Hold (en=1, mode=00): stages and fill unchanged.
REQ-015 Shift-up (en=1, mode=01): stage0 <= d; stage i <= stage i-1 for i = 1..DEPTH-1; the old stage DEPTH-1 is discarded.
REQ-016 Shift-down (en=1, mode=10): stage DEPTH-1 <= d; stage i <= stage i+1 for i = 0..DEPTH-2; the old stage0 is discarded.
REQ-017 Load (en=1, mode=11): all stages <= pd in one cycle; fill <= DEPTH.
REQ-018 Any enabled shift SHALL increment fill by 1, saturating at DEPTH; no wrap to 0.
REQ-019 Latency: a value on d during shift-up SHALL appear on q after exactly DEPTH enabled shift-up cycles; disabled cycles do not count.
REQ-020 Outputs SHALL be driven directly from registers, with no combinational path from inputs to outputs.
REQ-021 Mixing directions is legal; fill counts shifts in either direction and is not decremented.
REQ-022 full SHALL be asserted in the same cycle that fill reaches DEPTH.
REQ-023 en=0 with any mode, including 11, SHALL leave all state unchanged.

Reset
REQ-024 rst_n low SHALL immediately and asynchronously clear all stages to 0, fill to 0 and full to 0, with no clock edge required.
REQ-025 While rst_n is low, the clock SHALL be ignored.
REQ-026 After rst_n rises, the first state change SHALL occur at the first rising clk edge with en=1.
REQ-027 Reset asserted mid-shift SHALL win over any operation at the same edge.

Configuration
REQ-028 Macro SEQ_SHIFT_REG_ROTATE_EN, when defined, SHALL add input rot (1 bit).
REQ-029 With the macro defined and rot=1, the stage that would be discarded SHALL be fed back in place of d:
- shift-up: stage0 <= old stage DEPTH-1
- shift-down: stage DEPTH-1 <= old stage0
- fill behaves as in REQ-018.
REQ-030 With the macro defined and rot=0, or without the macro, behaviour SHALL be exactly REQ-014..REQ-023; without the macro, port rot SHALL NOT exist.

Verification
REQ-031 Reset then hold: rst_n=0 then released, en=1, mode=00 for 3 cycles -> q_all=0, fill=0, full=0.
REQ-032 Shift-up latency (WIDTH=8, DEPTH=4): d=0xA1,0xB2,0xC3,0xD4 over 4 cycles -> q=0xA1, q_lo=0xD4, fill=4, full=1 on the 4th edge; a 5th shift leaves fill=4.
REQ-033 Load then shift-down: pd={0x44,0x33,0x22,0x11}, mode=11, then mode=10 with d=0x55 -> q_all={0x55,0x44,0x33,0x22}, q_lo=0x22.
REQ-034 Enable gating: en=0 with mode=11 and pd nonzero for 2 cycles -> q_all and fill unchanged.
REQ-035 Asynchronous reset mid-operation: rst_n driven low between clock edges after 2 shifts -> q_all=0 and fill=0 before the next clk edge.
REQ-036 Rotate (macro defined): load {0x04,0x03,0x02,0x01}, rot=1, mode=01 for 4 cycles -> q_all returns to {0x04,0x03,0x02,0x01}.
